la_status_engine: RTL and testbench

User-project block that receives a test id and data words from the management core over the logic analyzer (LA) bus. It processes the words, returns a result over the LA bus, and verifies the host's echo of that result. Progress is reported on user GPIO as a 16-bit status code on `io_out[31:16]` and the current test id on `io_out[15:8]`. It sits inside the user project wrapper, between the LA/GPIO pins and the firmware-driven test sequence.

---
 rtl/la_status_pkg.sv | 47 ++++
 rtl/la_edge_det.sv | 27 ++
 rtl/la_status_engine.sv | 152 +++++++++++++++
 tb/tb_la_status_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/la_status_pkg.sv
// Shared types and constants for the LA status engine.
// Holds the state enum, GPIO status codes and LA bit positions.
package la_status_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_READ,
        S_PROC,
        S_WRITE,
        S_PASS,
        S_FAIL,
        S_ALLDONE
    } state_t;

    localparam logic [15:0] ST_IDLE    = 16'h0000;
    localparam logic [15:0] ST_START   = 16'hAB40;
    localparam logic [15:0] ST_READ    = 16'hAB41;
    localparam logic [15:0] ST_PROC    = 16'hAB42;
    localparam logic [15:0] ST_WRITE   = 16'hAB51;
    localparam logic [15:0] ST_PASS    = 16'hAB43;
    localparam logic [15:0] ST_FAIL    = 16'hAB44;
    localparam logic [15:0] ST_ALLDONE = 16'hABFF;

    localparam int LA_ID_LSB = 32;
    localparam int LA_VALID  = 40;
    localparam int LA_ACK    = 41;
    localparam int LA_FIN    = 42;
    localparam int LA_RVALID = 32;

    function automatic logic [15:0] status_of(input state_t s);
        logic [15:0] code;
        code = ST_IDLE;
        case (s)
            S_START:   code = ST_START;
            S_READ:    code = ST_READ;
            S_PROC:    code = ST_PROC;
            S_WRITE:   code = ST_WRITE;
            S_PASS:    code = ST_PASS;
            S_FAIL:    code = ST_FAIL;
            S_ALLDONE: code = ST_ALLDONE;
            default:   code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/la_edge_det.sv
// Masked rising-edge detector for LA control bits.
// A bit whose oenb is 1 is treated as 0 before edge detection.
module la_edge_det #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [W-1:0] data,
    input  logic [W-1:0] oenb,
    output logic [W-1:0] rise
);

    logic [W-1:0] live;
    logic [W-1:0] prev;

    assign live = data & ~oenb;
    assign rise = live & ~prev;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            prev <= '0;
        end else begin
            prev <= live;
        end
    end

endmodule

// File: rtl/la_status_engine.sv
// LA-driven test engine: reads words, sums them, returns the result
// and checks the host echo, reporting progress on GPIO.
module la_status_engine
    import la_status_pkg::*;
#(
    parameter int NWORDS      = 4,
    parameter int PROC_CYCLES = 8
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);

    localparam int PCW = $clog2(PROC_CYCLES + 1);
    localparam int PW  = (PCW > 5) ? PCW : 5;

    state_t        state;
    state_t        state_n;
    logic [2:0]    rise;
    logic          v_rise;
    logic          a_rise;
    logic          f_rise;
    logic [31:0]   data;
    logic [31:0]   words [16];
    logic [4:0]    cnt;
    logic [PW-1:0] pcnt;
    logic [31:0]   acc;
    logic [31:0]   addend;
    logic [7:0]    id;
    logic [15:0]   status;
    logic [15:0]   status_n;
    logic [31:0]   result;
    logic          res_valid;
    logic          res_valid_n;
    logic          cnt_full;
    logic          proc_done;
    logic          unused_la;

    la_edge_det #(.W(3)) u_edge (
        .clock  (clock),
        .resetb (resetb),
        .data   (la_data_in[LA_FIN:LA_VALID]),
        .oenb   (la_oenb[LA_FIN:LA_VALID]),
        .rise   (rise)
    );

    assign v_rise    = rise[0];
    assign a_rise    = rise[1];
    assign f_rise    = rise[2];
    assign data      = la_data_in[31:0];
    assign cnt_full  = (cnt == 5'(NWORDS));
    assign proc_done = (pcnt == PW'(PROC_CYCLES - 1));
    assign addend    = (pcnt < PW'(NWORDS)) ? words[pcnt[3:0]] : '0;

    assign unused_la = ^{la_data_in[127:43], la_oenb[127:43], la_oenb[39:0]};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (f_rise) begin
                    state_n = S_ALLDONE;
                end else if (v_rise) begin
                    state_n = S_START;
                end
            end
            S_START: state_n = S_READ;
            S_READ: begin
                if (cnt_full) state_n = S_PROC;
            end
            S_PROC: begin
                if (proc_done) state_n = S_WRITE;
            end
            S_WRITE: begin
                if (a_rise) state_n = (data == acc) ? S_PASS : S_FAIL;
            end
            S_ALLDONE: state_n = S_ALLDONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        status_n    = status_of(state_n);
        res_valid_n = (state_n == S_WRITE);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            status    <= '0;
            res_valid <= 1'b0;
            result    <= '0;
        end else begin
            status    <= status_n;
            res_valid <= res_valid_n;
            // The final add lands on the same edge that enters WRITE.
            if (state == S_PROC && state_n == S_WRITE) begin
                result <= acc + addend;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            id   <= '0;
            cnt  <= '0;
            pcnt <= '0;
            acc  <= '0;
            for (int i = 0; i < 16; i++) begin
                words[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (v_rise && !f_rise) begin
                        id   <= la_data_in[LA_ID_LSB +: 8];
                        cnt  <= '0;
                        pcnt <= '0;
                        acc  <= '0;
                    end
                end
                S_READ: begin
                    if (!cnt_full && v_rise) begin
                        words[cnt[3:0]] <= data;
                        cnt             <= cnt + 5'd1;
                    end
                end
                S_PROC: begin
                    pcnt <= pcnt + PW'(1);
                    acc  <= acc + addend;
                end
                default: ;
            endcase
        end
    end

    assign la_data_out = {95'b0, res_valid, result};
    assign io_out      = {6'b0, status, id, 8'b0};
    assign io_oeb      = {6'h3F, 24'h0, 8'hFF};

endmodule

// File: tb/tb_la_status_engine.sv
// Self-checking bench for la_status_engine: table vectors, random
// vectors against a sum model, and hand-written corner sequences.
module tb_la_status_engine;

    localparam int NW = 4;
    localparam int PC = 8;

    localparam logic [15:0] C_IDLE  = 16'h0000;
    localparam logic [15:0] C_START = 16'hAB40;
    localparam logic [15:0] C_READ  = 16'hAB41;
    localparam logic [15:0] C_PROC  = 16'hAB42;
    localparam logic [15:0] C_WRITE = 16'hAB51;
    localparam logic [15:0] C_PASS  = 16'hAB43;
    localparam logic [15:0] C_FAIL  = 16'hAB44;
    localparam logic [15:0] C_DONE  = 16'hABFF;

    typedef struct {
        logic [7:0]       tid;
        logic [3:0][31:0] w;
        logic [31:0]      echo;
        logic [31:0]      sum;
        bit               pass;
    } vec_t;

    logic         clock = 1'b0;
    logic         resetb;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [15:0]  status;
    logic [7:0]   id_out;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[2];

    always #5 clock = ~clock;

    assign status = io_out[31:16];
    assign id_out = io_out[15:8];

    la_status_engine #(.NWORDS(NW), .PROC_CYCLES(PC)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Upper bits get random junk; the design must ignore them.
    task automatic set_in(input logic [31:0] d, input logic [7:0] tid,
                          input logic v, input logic a, input logic f);
        la_data_in         = {$urandom(), $urandom(), $urandom(), $urandom()};
        la_data_in[31:0]   = d;
        la_data_in[39:32]  = tid;
        la_data_in[40]     = v;
        la_data_in[41]     = a;
        la_data_in[42]     = f;
    endtask

    function automatic logic [31:0] model_sum(input logic [3:0][31:0] w);
        longint unsigned s = 0;
        for (int i = 0; i < NW; i++) s += longint'(w[i]);
        return s[31:0];
    endfunction

    task automatic run_test(input logic [7:0] tid, input logic [3:0][31:0] w,
                            input logic [31:0] echo, input logic [31:0] sum,
                            input bit pass, input bit fin_mid);
        set_in(32'h0, tid, 1, 0, 0);
        tick();
        chk("start_status", status, C_START);
        chk("start_id", id_out, tid);
        set_in(32'h0, tid, 0, 0, 0);
        tick();
        chk("read_status", status, C_READ);
        for (int i = 0; i < NW; i++) begin
            set_in(w[i], 8'h00, 1, 0, 0);
            tick();
            chk("read_cap", status, C_READ);
            set_in(32'h0, 8'h00, 0, 0, 0);
            tick();
            chk("read_next", status, (i == NW - 1) ? C_PROC : C_READ);
            if (fin_mid && i == 1) begin
                set_in(32'h0, 8'h00, 0, 1, 1);
                tick();
                chk("fin_in_read", status, C_READ);
                set_in(32'h0, 8'h00, 0, 0, 0);
                tick();
                chk("fin_in_read2", status, C_READ);
            end
        end
        for (int k = 1; k < PC; k++) tick();
        chk("proc_len", status, C_PROC);
        chk("proc_rvalid", la_data_out[32], 1'b0);
        tick();
        chk("write_status", status, C_WRITE);
        chk("write_result", la_data_out[31:0], sum);
        chk("write_rvalid", la_data_out[32], 1'b1);
        chk("write_upper", la_data_out[127:33], '0);
        set_in(echo, 8'h00, 0, 1, 0);
        tick();
        chk("verdict", status, pass ? C_PASS : C_FAIL);
        chk("verdict_rvalid", la_data_out[32], 1'b0);
        chk("verdict_id", id_out, tid);
        set_in(32'h0, 8'h00, 0, 0, 0);
        tick();
        tick();
        chk("verdict_hold", status, pass ? C_PASS : C_FAIL);
        chk("io_out_full", io_out, {6'b0, pass ? C_PASS : C_FAIL, tid, 8'h00});
    endtask

    initial begin
        logic [3:0][31:0] w;
        logic [31:0]      s;
        logic [31:0]      e;

        tbl[0].tid = 8'h01;
        tbl[0].w   = {32'd4, 32'd3, 32'd2, 32'd1};
        tbl[0].echo = 32'd10;
        tbl[0].sum = 32'd10;
        tbl[0].pass = 1'b1;
        tbl[1].tid = 8'h02;
        tbl[1].w   = {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF};
        tbl[1].echo = 32'd5;
        tbl[1].sum = 32'd0;
        tbl[1].pass = 1'b0;

        resetb  = 1'b0;
        la_oenb = '0;
        set_in(32'h0, 8'h00, 0, 0, 0);
        tick();
        tick();
        resetb = 1'b1;
        tick();
        chk("rst_status", status, C_IDLE);
        chk("rst_io_out", io_out, '0);
        chk("rst_io_oeb", io_oeb, {6'h3F, 24'h0, 8'hFF});
        chk("rst_la_out", la_data_out, '0);

        for (int i = 0; i < 2; i++) begin
            run_test(tbl[i].tid, tbl[i].w, tbl[i].echo, tbl[i].sum,
                     tbl[i].pass, 1'b0);
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) begin
                w[i] = (r < 3) ? (32'hF000_0000 | $urandom()) : $urandom();
            end
            s = model_sum(w);
            e = (r % 2 == 1) ? s : (s ^ (32'd1 << $urandom_range(31, 0)));
            run_test(8'($urandom_range(255, 3)), w, e, s, e == s, 1'b0);
        end

        run_test(8'h11, {32'd40, 32'd30, 32'd20, 32'd10}, 32'd100,
                 32'd100, 1'b1, 1'b1);

        // A masked cmd_valid must never register a rise.
        la_oenb[40] = 1'b1;
        set_in(32'h0, 8'h55, 1, 0, 0);
        tick();
        tick();
        chk("masked_valid", status, C_PASS);
        set_in(32'h0, 8'h00, 0, 0, 0);
        tick();
        la_oenb[40] = 1'b0;
        tick();
        chk("masked_id", id_out, 8'h11);

        set_in(32'h0, 8'h21, 1, 0, 0);
        tick();
        set_in(32'h0, 8'h21, 0, 0, 0);
        tick();
        for (int i = 0; i < NW; i++) begin
            set_in(32'h1234 + 32'(i), 8'h00, 1, 0, 0);
            tick();
            set_in(32'h0, 8'h00, 0, 0, 0);
            tick();
        end
        tick();
        tick();
        tick();
        chk("pre_rst_proc", status, C_PROC);
        #2;
        resetb = 1'b0;
        #1;
        chk("midrst_status", status, C_IDLE);
        chk("midrst_la_out", la_data_out, '0);
        chk("midrst_io_out", io_out, '0);
        tick();
        tick();
        chk("rst_held", status, C_IDLE);
        resetb = 1'b1;
        tick();
        run_test(tbl[0].tid, tbl[0].w, tbl[0].echo, tbl[0].sum,
                 tbl[0].pass, 1'b0);

        set_in(32'h0, 8'h00, 0, 0, 1);
        tick();
        chk("alldone", status, C_DONE);
        set_in(32'h0, 8'h00, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(32'h0, 8'h66, 1, 1, 0);
            tick();
            set_in(32'h0, 8'h66, 0, 0, 0);
            tick();
        end
        chk("alldone_stay", status, C_DONE);
        chk("alldone_id", id_out, 8'h01);
        chk("alldone_rvalid", la_data_out[32], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
